// File: rtl/gray_counter.sv
// gray_counter: registered Gray-code counter with enable, synchronous load
// of a Gray-coded value, a one-cycle wrap pulse and optional down-counting.
// The count is kept in binary (bin_r). The Gray code is derived from the
// next binary value and then registered, so gray_o never shows an
// intermediate code.
// Optional feature macro: GRAY_COUNTER_DOWN_EN. When it is defined, up_i
// selects the count direction. When it is undefined, the counter is up-only
// and up_i is not used.
// Per-cycle priority: reset_i > load_i > en_i > hold.

module gray_counter #(
  parameter int width_p = 5
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic               up_i,
  input  logic               load_i,
  input  logic [width_p-1:0] load_gray_i,
  output logic [width_p-1:0] gray_o,
  output logic               wrap_o
);

  localparam logic [width_p-1:0] one_c = width_p'(1);

  logic [width_p-1:0] bin_r;
  logic [width_p-1:0] bin_n;
  logic [width_p-1:0] gray_n;
  logic               wrap_n;
  logic               step_up;
  logic               step_dn;

  // Gray to binary: each binary bit is the XOR of all Gray bits at and above it.
  function automatic logic [width_p-1:0] gray_to_bin(input logic [width_p-1:0] g);
    logic [width_p-1:0] b;
    b[width_p-1] = g[width_p-1];
    for (int i = width_p - 2; i >= 0; i--) begin
      b[i] = g[i] ^ b[i+1];
    end
    return b;
  endfunction

`ifdef GRAY_COUNTER_DOWN_EN
  // Decode the direction of an enabled step. The load has priority over a step.
  always_comb begin
    step_up = en_i && !load_i && up_i;
    step_dn = en_i && !load_i && !up_i;
  end
`else
  // Up-only build. up_i is deliberately left unconsumed here.
  logic unused_up;
  assign unused_up = up_i;

  // Decode an enabled step. The load has priority, and the step is always upward.
  always_comb begin
    step_up = en_i && !load_i;
    step_dn = 1'b0;
  end
`endif

  // Next binary value and wrap flag. Gray is encoded from the next value.
  always_comb begin
    bin_n  = bin_r;
    wrap_n = 1'b0;
    if (load_i) begin
      bin_n = gray_to_bin(load_gray_i);
    end else if (step_up) begin
      bin_n  = bin_r + one_c;
      wrap_n = &bin_r;
    end else if (step_dn) begin
      bin_n  = bin_r - one_c;
      wrap_n = ~|bin_r;
    end
    gray_n = bin_n ^ (bin_n >> 1);
  end

  // State and output registers. The synchronous reset overrides everything.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bin_r  <= '0;
      gray_o <= '0;
      wrap_o <= 1'b0;
    end else begin
      bin_r  <= bin_n;
      gray_o <= gray_n;
      wrap_o <= wrap_n;
    end
  end

endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter at width_p = 4. The reference model tracks the
// position in the Gray sequence. That sequence is built by the reflect-and-
// prefix construction, not by XOR-shifting the binary value.

module tb_gray_counter;

  localparam int W = 4;
  localparam int N = 1 << W;

  logic         clk_i = 1'b0;
  logic         reset_i = 1'b1;
  logic         en_i = 1'b0;
  logic         up_i = 1'b1;
  logic         load_i = 1'b0;
  logic [W-1:0] load_gray_i = '0;
  logic [W-1:0] gray_o;
  logic         wrap_o;

  int tests_run = 0;
  int tests_failed = 0;

  int gray_seq [0:N-1];
  int mdl_pos = 0;
  int mdl_wrap = 0;

  gray_counter #(.width_p(W)) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .en_i        (en_i),
    .up_i        (up_i),
    .load_i      (load_i),
    .load_gray_i (load_gray_i),
    .gray_o      (gray_o),
    .wrap_o      (wrap_o)
  );

  // clock / reset block
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pos_of(input int g);
    for (int i = 0; i < N; i++) if (gray_seq[i] == g) return i;
    return 0;
  endfunction

  // Driver plus model update for one clock cycle. Outputs are checked 1 time unit after the edge.
  task automatic drive_cycle(input logic rst, input logic en, input logic up,
                             input logic ld, input logic [W-1:0] lg);
    logic [W-1:0] prev;
    logic         counting;
    reset_i = rst; en_i = en; up_i = up; load_i = ld; load_gray_i = lg;
    prev = gray_o;
    counting = !rst && !ld && en;
    @(posedge clk_i);
    if (rst) begin
      mdl_pos = 0; mdl_wrap = 0;
    end else if (ld) begin
      mdl_pos = pos_of(int'(lg)); mdl_wrap = 0;
    end else if (en) begin
`ifdef GRAY_COUNTER_DOWN_EN
      if (!up) begin
        mdl_wrap = (mdl_pos == 0) ? 1 : 0;
        mdl_pos = (mdl_pos + N - 1) % N;
      end else begin
        mdl_wrap = (mdl_pos == N - 1) ? 1 : 0;
        mdl_pos = (mdl_pos + 1) % N;
      end
`else
      mdl_wrap = (mdl_pos == N - 1) ? 1 : 0;
      mdl_pos = (mdl_pos + 1) % N;
`endif
    end else begin
      mdl_wrap = 0;
    end
    #1;
    check("gray", 32'(gray_o), 32'(gray_seq[mdl_pos]));
    check("wrap", 32'(wrap_o), 32'(mdl_wrap));
    if (counting) check("hamming", 32'($countones(prev ^ gray_o)), 32'd1);
  endtask

  int up_exp [0:N-1] = '{1, 3, 2, 6, 7, 5, 4, 'hC, 'hD, 'hF, 'hE, 'hA, 'hB, 9, 8, 0};

  initial begin
    int len;
    gray_seq[0] = 0;
    len = 1;
    for (int b = 0; b < W; b++) begin
      for (int i = 0; i < len; i++) gray_seq[len + i] = gray_seq[len - 1 - i] | (1 << b);
      len = len * 2;
    end

    // reset state
    drive_cycle(1, 0, 1, 0, '0);
    drive_cycle(1, 1, 1, 1, 4'hF);
    check("reset_gray", 32'(gray_o), 32'd0);
    check("reset_wrap", 32'(wrap_o), 32'd0);

    // full up sequence of 16 steps
    for (int i = 0; i < N; i++) begin
      drive_cycle(0, 1, 1, 0, '0);
      check("seq_up", 32'(gray_o), 32'(up_exp[i]));
      check("seq_wrap", 32'(wrap_o), (i == N - 1) ? 32'd1 : 32'd0);
    end

    // a load together with en: the load wins, then one step
    drive_cycle(0, 1, 1, 1, 4'hC);
    check("load_c", 32'(gray_o), 32'hC);
    drive_cycle(0, 1, 1, 0, '0);
    check("load_step", 32'(gray_o), 32'hD);

    // down count, or up-only behaviour, starting from reset
    drive_cycle(1, 0, 1, 0, '0);
    drive_cycle(0, 1, 0, 0, '0);
`ifdef GRAY_COUNTER_DOWN_EN
    check("down_0", 32'(gray_o), 32'h8);
    check("down_wrap", 32'(wrap_o), 32'd1);
    drive_cycle(0, 1, 0, 0, '0);
    check("down_1", 32'(gray_o), 32'h9);
    drive_cycle(0, 1, 0, 0, '0);
    check("down_2", 32'(gray_o), 32'hB);
`else
    check("uponly_0", 32'(gray_o), 32'h1);
    drive_cycle(0, 1, 0, 0, '0);
    check("uponly_1", 32'(gray_o), 32'h3);
    drive_cycle(0, 1, 0, 0, '0);
    check("uponly_2", 32'(gray_o), 32'h2);
`endif

    // reset mid-count at gray 7 overrides load and en
    drive_cycle(1, 0, 1, 0, '0);
    for (int i = 0; i < 5; i++) drive_cycle(0, 1, 1, 0, '0);
    check("at_7", 32'(gray_o), 32'h7);
    drive_cycle(1, 1, 1, 1, 4'h9);
    check("midrst_gray", 32'(gray_o), 32'd0);
    check("midrst_wrap", 32'(wrap_o), 32'd0);

    // hold at gray 6 for 5 cycles
    for (int i = 0; i < 4; i++) drive_cycle(0, 1, 1, 0, '0);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(0, 0, 1, 0, '0);
      check("hold_gray", 32'(gray_o), 32'h6);
      check("hold_wrap", 32'(wrap_o), 32'd0);
    end

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      drive_cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0),
                  W'($urandom_range(0, N - 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
